// File: rtl/dht_sensor_reader.sv
// Single-wire DHT11/DHT22 reader: start pulse, response/bit timing, checksum and 0.1-unit
// conversion. Defining DHT_ERRCNT_EN adds a saturating err_cnt output.
module dht_sensor_reader #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned SENSOR_TYPE   = 1,
    parameter int unsigned AUTO_MODE     = 1,
    parameter int unsigned POWER_ON_US   = 1_000_000,
    parameter int unsigned PERIOD_US     = 2_000_000,
    parameter int unsigned BIT_THRESH_US = 50,
    parameter int unsigned TIMEOUT_US    = 200
) (
    input  logic        clk,
    input  logic        res,
    inout  wire         dht_io,
    input  logic        start,
    output logic        busy,
    output logic [15:0] hum,
    output logic [15:0] temp,
    output logic        data_valid,
    output logic        crc_err,
    output logic        timeout_err
`ifdef DHT_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int unsigned Div     = CLK_HZ / 1_000_000;
    localparam int unsigned StartUs = (SENSOR_TYPE == 0) ? 18_000 : 1_000;

    typedef enum logic [3:0] {
        StPowerWait,
        StIdle,
        StStartLow,
        StRelease,
        StRespLow,
        StRespHigh,
        StDataLow,
        StDataHigh,
        StCheck,
        StHoldoff
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pre_q, pre_d;
    logic [2:0]  sync_q, sync_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] per_q, per_d;
    logic [5:0]  bits_q, bits_d;
    logic [38:0] shift_q, shift_d;
    logic [15:0] hum_q, hum_d;
    logic [15:0] temp_q, temp_d;
    logic        dv_q, dv_d;
    logic        ce_q, ce_d;
    logic        te_q, te_d;

    logic        us_tick;
    logic        rise, fall;
    logic        bit_now;
    logic        phase_to;
    logic [39:0] frame;
    logic [7:0]  b0, b1, b2, b3, b4, sum;
    logic [15:0] mag22, mag11, hum_conv, temp_conv;

    assign us_tick = (pre_q == Div - 1);
    assign pre_d   = us_tick ? 32'd0 : pre_q + 32'd1;

    // sync_q[2] is the previous synchronised sample, used only for edge detection.
    assign sync_d = {sync_q[1:0], dht_io};
    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];

    assign bit_now  = (cnt_q > BIT_THRESH_US);
    assign phase_to = (cnt_q >= TIMEOUT_US);

    // The frame as it stands once the bit now ending is shifted in.
    assign frame              = {shift_q, bit_now};
    assign {b0, b1, b2, b3, b4} = frame;
    assign sum                = b0 + b1 + b2 + b3;
    assign mag22              = {1'b0, b2[6:0], b3};
    assign mag11              = 16'(b2) * 16'd10 + {12'd0, b3[3:0]};

    always_comb begin
        hum_conv  = {b0, b1};
        temp_conv = b2[7] ? -mag22 : mag22;
        if (SENSOR_TYPE == 0) begin
            hum_conv  = 16'(b0) * 16'd10 + {12'd0, b1[3:0]};
            temp_conv = b3[7] ? -mag11 : mag11;
        end
    end

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        hum_d   = hum_q;
        temp_d  = temp_q;
        dv_d    = 1'b0;
        ce_d    = 1'b0;
        te_d    = 1'b0;
        unique case (state_q)
            StPowerWait: if (cnt_q >= POWER_ON_US) state_d = StIdle;
            StIdle: begin
                if ((AUTO_MODE != 0) || start) begin
                    state_d = StStartLow;
                    bits_d  = '0;
                    shift_d = '0;
                end
            end
            StStartLow: if (cnt_q >= StartUs) state_d = StRelease;
            StRelease: begin
                if (fall) state_d = StRespLow;
                else if (phase_to) begin
                    state_d = StHoldoff;
                    te_d    = 1'b1;
                end
            end
            StRespLow: begin
                if (rise) state_d = StRespHigh;
                else if (phase_to) begin
                    state_d = StHoldoff;
                    te_d    = 1'b1;
                end
            end
            StRespHigh: begin
                if (fall) begin
                    state_d = StDataLow;
                    bits_d  = '0;
                    shift_d = '0;
                end else if (phase_to) begin
                    state_d = StHoldoff;
                    te_d    = 1'b1;
                end
            end
            StDataLow: begin
                if (rise) state_d = StDataHigh;
                else if (phase_to) begin
                    state_d = StHoldoff;
                    te_d    = 1'b1;
                end
            end
            StDataHigh: begin
                if (fall) begin
                    shift_d = frame[38:0];
                    bits_d  = bits_q + 6'd1;
                    state_d = StDataLow;
                    if (bits_q == 6'd39) begin
                        state_d = StCheck;
                        if (sum == b4) begin
                            hum_d  = hum_conv;
                            temp_d = temp_conv;
                            dv_d   = 1'b1;
                        end else begin
                            ce_d = 1'b1;
                        end
                    end
                end else if (phase_to) begin
                    state_d = StHoldoff;
                    te_d    = 1'b1;
                end
            end
            StCheck: state_d = StHoldoff;
            StHoldoff: if (per_q >= PERIOD_US) state_d = StIdle;
            default: state_d = StPowerWait;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (us_tick && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    // Start-to-start spacing is measured from START_LOW entry, across the whole read.
    always_comb begin
        per_d = per_q;
        if ((state_d == StStartLow) && (state_q != StStartLow)) per_d = '0;
        else if (us_tick && (per_q < PERIOD_US)) per_d = per_q + 32'd1;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= StPowerWait;
            pre_q   <= '0;
            sync_q  <= 3'b111;
            cnt_q   <= '0;
            per_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            hum_q   <= '0;
            temp_q  <= '0;
            dv_q    <= 1'b0;
            ce_q    <= 1'b0;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            hum_q   <= hum_d;
            temp_q  <= temp_d;
            dv_q    <= dv_d;
            ce_q    <= ce_d;
            te_q    <= te_d;
        end
    end

    assign dht_io      = (state_q == StStartLow) ? 1'b0 : 1'bz;
    assign busy        = (state_q != StPowerWait) && (state_q != StIdle);
    assign hum         = hum_q;
    assign temp        = temp_q;
    assign data_valid  = dv_q;
    assign crc_err     = ce_q;
    assign timeout_err = te_q;

`ifdef DHT_ERRCNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((ce_q || te_q) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) err_q <= '0;
        else     err_q <= err_d;
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_dht_sensor_reader.sv
// Scoreboard bench for dht_sensor_reader: a DHT22 reader in start mode and a DHT11 reader in
// auto mode, each served by a behavioural sensor model on a pulled-up bus.
`timescale 1ns/1ps
module tb_dht_sensor_reader;

    localparam int unsigned ACpu    = 2;
    localparam int unsigned BCpu    = 1;
    localparam int unsigned APeriod = 2200;
    localparam int unsigned ATmo    = 40;
    localparam longint      ClkNs   = 10;

    typedef struct {
        int          kind;  // 0 data_valid, 1 crc_err, 2 timeout_err
        logic [15:0] hum;
        logic [15:0] temp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res_a, res_b, start_a, start_b;
    logic        drv_a, drv_b;
    wire         bus_a, bus_b;
    logic        busy_a, dv_a, ce_a, te_a, busy_b, dv_b, ce_b, te_b;
    logic [15:0] hum_a, temp_a, hum_b, temp_b;
`ifdef DHT_ERRCNT_EN
    logic [15:0] err_a, err_b;
`endif

    pullup pu_a (bus_a);
    pullup pu_b (bus_b);
    assign bus_a = drv_a ? 1'b0 : 1'bz;
    assign bus_b = drv_b ? 1'b0 : 1'bz;

    dht_sensor_reader #(
        .CLK_HZ(2_000_000), .SENSOR_TYPE(1), .AUTO_MODE(0), .POWER_ON_US(20),
        .PERIOD_US(APeriod), .BIT_THRESH_US(10), .TIMEOUT_US(ATmo)
    ) u_dut_a (
        .clk(clk), .res(res_a), .dht_io(bus_a), .start(start_a), .busy(busy_a),
        .hum(hum_a), .temp(temp_a), .data_valid(dv_a), .crc_err(ce_a), .timeout_err(te_a)
`ifdef DHT_ERRCNT_EN
        , .err_cnt(err_a)
`endif
    );

    dht_sensor_reader #(
        .CLK_HZ(1_000_000), .SENSOR_TYPE(0), .AUTO_MODE(1), .POWER_ON_US(20),
        .PERIOD_US(30_000), .BIT_THRESH_US(10), .TIMEOUT_US(40)
    ) u_dut_b (
        .clk(clk), .res(res_b), .dht_io(bus_b), .start(start_b), .busy(busy_b),
        .hum(hum_b), .temp(temp_b), .data_valid(dv_b), .crc_err(ce_b), .timeout_err(te_b)
`ifdef DHT_ERRCNT_EN
        , .err_cnt(err_b)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] last_h_a = '0, last_t_a = '0;
    int          n_err_a = 0;
    int          te_cnt_a = 0;
    longint      te_time_a = 0;
    exp_t        mon_e;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input longint got, input longint lo,
                               input longint hi);
        n_tests++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Reference: checksum and unit conversion straight from the byte-level rules.
    function automatic exp_t model(input int sensor, input logic [39:0] f,
                                   input logic [15:0] lh, input logic [15:0] lt);
        int b[5];
        int h, t;
        exp_t e;
        for (int i = 0; i < 5; i++) b[i] = int'(f[39-8*i -: 8]);
        e.kind = 1;
        e.hum  = lh;
        e.temp = lt;
        if ((b[0] + b[1] + b[2] + b[3]) % 256 != b[4]) return e;
        if (sensor == 1) begin
            h = b[0] * 256 + b[1];
            t = (b[2] % 128) * 256 + b[3];
            if (b[2] >= 128) t = -t;
        end else begin
            h = b[0] * 10 + b[1] % 16;
            t = b[2] * 10 + b[3] % 16;
            if (b[3] >= 128) t = -t;
        end
        e.kind = 0;
        e.hum  = 16'(h);
        e.temp = 16'(t);
        return e;
    endfunction

    function automatic logic bus_val(input int idx);
        return (idx == 0) ? bus_a : bus_b;
    endfunction

    task automatic hold(input int idx, input bit pull_low, input int n);
        if (idx == 0) drv_a = pull_low;
        else drv_b = pull_low;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sensor_read(input int idx, input int cpu, input logic [39:0] f,
                               input bit silent, input int start_bit, input int abort_bit,
                               output int low_clks, output bit ok, output longint t_low,
                               output longint t_rel);
        int t, hi;
        ok = 1'b0;
        low_clks = 0;
        t = 0;
        t_low = 0;
        t_rel = 0;
        while (bus_val(idx) != 1'b0 && t < 40000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 40000) return;
        t_low = longint'($time);
        while (bus_val(idx) == 1'b0 && low_clks < 40000) begin
            @(posedge clk);
            #1;
            low_clks++;
        end
        t_rel = longint'($time);
        ok = 1'b1;
        if (silent) return;
        hold(idx, 1'b0, 10 * cpu);
        hold(idx, 1'b1, 30 * cpu);
        hold(idx, 1'b0, 30 * cpu);
        for (int i = 39; i >= 0; i--) begin
            hold(idx, 1'b1, 6 * cpu);
            if (i == abort_bit) begin
                res_a = 1'b1;
                hold(idx, 1'b0, 0);
                return;
            end
            hi = f[i] ? int'($urandom_range(12, 18)) : int'($urandom_range(2, 4));
            hi = hi * cpu;
            if (i == start_bit) begin
                hold(idx, 1'b0, 4);
                start_a = 1'b1;
                @(posedge clk);
                #1;
                start_a = 1'b0;
                hold(idx, 1'b0, hi - 5);
            end else begin
                hold(idx, 1'b0, hi);
            end
        end
        hold(idx, 1'b1, 6 * cpu);
        hold(idx, 1'b0, 0);
    endtask

    task automatic pulse_start();
        check("a_busy_before_start", busy_a, 0);
        @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        check("a_busy_after_start", busy_a, 1);
    endtask

    task automatic wait_idle_a(output longint t_fall);
        int t = 0;
        while (busy_a && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        t_fall = longint'($time);
        check("a_busy_falls_in_time", longint'(t < 20000), 1);
    endtask

    task automatic expect_quiet_a(input string name, input int n);
        int bad = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus_a == 1'b0 || busy_a) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic a_read(input logic [39:0] f, input int start_bit, output longint t_low);
        exp_t   e;
        int     lowc;
        bit     ok;
        longint t_rel, t_fall;
        e = model(1, f, last_h_a, last_t_a);
        if (e.kind == 0) begin
            last_h_a = e.hum;
            last_t_a = e.temp;
        end else begin
            n_err_a++;
        end
        q_a.push_back(e);
        pulse_start();
        sensor_read(0, ACpu, f, 1'b0, start_bit, -1, lowc, ok, t_low, t_rel);
        check("a_start_seen", longint'(ok), 1);
        check_range("a_start_low_clks", lowc, 2000 - 4, 2000 + 4);
        wait_idle_a(t_fall);
    endtask

    function automatic logic [39:0] rnd_frame(input bit corrupt);
        logic [7:0] b[4];
        logic [7:0] s;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
        s = b[0] + b[1] + b[2] + b[3];
        if (corrupt) s = s ^ (8'd1 << $urandom_range(0, 7));
        return {b[0], b[1], b[2], b[3], s};
    endfunction

    always @(negedge clk) begin
        if (!res_a && (dv_a || ce_a || te_a)) begin
            check("a_pulse_exclusive", int'(dv_a) + int'(ce_a) + int'(te_a), 1);
            if (te_a) begin
                te_cnt_a  <= te_cnt_a + 1;
                te_time_a <= longint'($time);
            end
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_pulse: got dv=%0d ce=%0d te=%0d, expected none",
                         dv_a, ce_a, te_a);
            end else begin
                mon_e = q_a.pop_front();
                check("a_status_kind", dv_a ? 0 : (ce_a ? 1 : 2), mon_e.kind);
                check("a_hum", hum_a, mon_e.hum);
                check("a_temp", temp_a, mon_e.temp);
            end
        end
        if (!res_b && (dv_b || ce_b || te_b)) begin
            check("b_pulse_exclusive", int'(dv_b) + int'(ce_b) + int'(te_b), 1);
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_pulse: got dv=%0d ce=%0d te=%0d, expected none",
                         dv_b, ce_b, te_b);
            end else begin
                mon_e = q_b.pop_front();
                check("b_status_kind", dv_b ? 0 : (ce_b ? 1 : 2), mon_e.kind);
                check("b_hum", hum_b, mon_e.hum);
                check("b_temp", temp_b, mon_e.temp);
            end
        end
    end

    initial begin
        longint t_low, t_prev, t_rel, t_fall;
        int     lowc, cnt, te_before;
        bit     ok;
        exp_t   e;

        res_a = 1'b1;
        res_b = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        drv_a = 1'b0;
        drv_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_bus_released", bus_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_hum", hum_a, 0);
        check("rst_temp", temp_a, 0);
        check("rst_pulses", {dv_a, ce_a, te_a}, 0);
        check("rst_b_outputs", {busy_b, dv_b, ce_b, te_b, hum_b, temp_b}, 0);
`ifdef DHT_ERRCNT_EN
        check("rst_err_cnt", err_a, 0);
`endif
        res_a = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("a_manual_idle_not_busy", busy_a, 0);

        a_read(40'h02_8C_01_5F_EE, -1, t_low);
        a_read(40'h02_8C_80_65_73, -1, t_low);
        a_read(40'h02_8C_01_5F_EF, -1, t_low);
        for (int i = 0; i < 3; i++) a_read(rnd_frame(i == 1), -1, t_low);

        // Start during DATA_HIGH of bit 35 (a 1 bit) must not queue another read.
        a_read(40'hFF_00_12_34_45, 35, t_low);
        expect_quiet_a("a_start_not_queued", 60);

        e.kind = 2;
        e.hum  = last_h_a;
        e.temp = last_t_a;
        q_a.push_back(e);
        n_err_a++;
        te_before = te_cnt_a;
        pulse_start();
        sensor_read(0, ACpu, 40'd0, 1'b1, -1, -1, lowc, ok, t_low, t_rel);
        cnt = 0;
        while (te_cnt_a == te_before && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("a_timeout_seen", longint'(cnt < 1000), 1);
        check_range("a_timeout_after_release_clks", (te_time_a - t_rel) / ClkNs,
                    ATmo * ACpu - 4, ATmo * ACpu + 4);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_idle_a(t_fall);
        check_range("a_holdoff_end_clks", (t_fall - t_low) / ClkNs,
                    APeriod * ACpu - 2, APeriod * ACpu + 6);
        expect_quiet_a("a_holdoff_start_ignored", 30);
        t_prev = t_low;
        a_read(rnd_frame(1'b0), -1, t_low);
        check("a_start_spacing_ok", longint'((t_low - t_prev) / ClkNs >= APeriod * ACpu), 1);
`ifdef DHT_ERRCNT_EN
        check("a_err_cnt", err_a, n_err_a);
`endif

        // Reset mid-frame, at bit 20.
        pulse_start();
        sensor_read(0, ACpu, 40'h55_66_77_11_43, 1'b0, -1, 20, lowc, ok, t_low, t_rel);
        #1;
        check("midreset_busy", busy_a, 0);
        check("midreset_hum", hum_a, 0);
        check("midreset_temp", temp_a, 0);
        check("midreset_pulses", {dv_a, ce_a, te_a}, 0);
`ifdef DHT_ERRCNT_EN
        check("midreset_err_cnt", err_a, 0);
`endif
        repeat (3) @(posedge clk);
        #1 res_a = 1'b0;
        last_h_a = '0;
        last_t_a = '0;
        repeat (60) @(posedge clk);
        #1;

        // Reset while the reader holds the bus low.
        pulse_start();
        repeat (50) @(posedge clk);
        #1;
        check("a_bus_driven_low", bus_a, 0);
        res_a = 1'b1;
        #1;
        check("a_bus_released_on_reset", bus_a, 1);
        check("a_busy_cleared_on_reset", busy_a, 0);
        repeat (3) @(posedge clk);
        #1 res_a = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        a_read(40'h02_8C_01_5F_EE, -1, t_low);

        e = model(0, 40'h2D_00_17_00_44, 16'd0, 16'd0);
        q_b.push_back(e);
        res_b = 1'b0;
        sensor_read(1, BCpu, 40'h2D_00_17_00_44, 1'b0, -1, -1, lowc, ok, t_low, t_rel);
        check("b_start_seen", longint'(ok), 1);
        check_range("b_start_low_clks", lowc, 18000 - 3, 18000 + 3);
        cnt = 0;
        while (q_b.size() != 0 && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("b_result_in_time", longint'(cnt < 2000), 1);
        check("b_busy_in_holdoff", busy_b, 1);
        check("a_queue_drained", q_a.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dht_sensor_reader.md
# dht_sensor_reader

Parametrised single-wire reader for DHT11/DHT22-class humidity/temperature sensors. It sits between the open-drain sensor pin and the RFS sensor register block. It generates the start pulse, times the response and the 40 data bits, and verifies the checksum. It presents humidity and signed temperature in uniform 0.1-unit fixed point, with per-read status. It supersedes the fixed-rate DHT22-only reader: configurable clock rate, sensor type, trigger mode and timeouts, with explicit error reporting.

## Interface
- CLK_HZ, 50_000_000: system clock frequency; must be an integer multiple of 1 MHz.
- SENSOR_TYPE, 1: 0 = DHT11, 1 = DHT22.
- AUTO_MODE, 1: 1 = free-running reads every PERIOD_US; 0 = read only on `start`.
- POWER_ON_US, 1_000_000: settle time after reset before the first read.
- PERIOD_US, 2_000_000: minimum spacing between start pulses. Enforced in both modes.
- BIT_THRESH_US, 50: data-high duration strictly greater than this decodes as 1.
- TIMEOUT_US, 200: maximum duration of any single sensor-driven phase.
- clk  in  1  system clock.
- res  in  1  asynchronous, active-high reset.
- dht_io  inout  1  sensor bus. Driven 0 or high-Z only, never driven 1.
- start  in  1  single-cycle read request. Used only when AUTO_MODE=0.
- busy  out  1  high from the start pulse through the end of HOLDOFF.
- hum  out  16  relative humidity, unsigned, 0.1 %RH.
- temp  out  16  temperature, two's complement, 0.1 °C.
- data_valid  out  1  one-cycle pulse when hum/temp update.
- crc_err  out  1  one-cycle pulse on checksum mismatch.
- timeout_err  out  1  one-cycle pulse on any phase timeout.

## Operation
- A prescaler produces `us_tick`, a one-clk enable every CLK_HZ/1e6 cycles. There is no derived clock. All µs counters advance on `us_tick` only.
- `dht_io` passes through a 2-FF synchroniser in the clk domain. Rise and fall edges are detected on the synchronised value.
- States:
  - POWER_WAIT: wait POWER_ON_US, then go to IDLE.
  - IDLE: in AUTO_MODE=1, go to START_LOW immediately. In AUTO_MODE=0, go to START_LOW on `start`.
  - START_LOW: drive 0 for 18_000 µs (DHT11) or 1_000 µs (DHT22), then release the bus.
  - RELEASE: wait for a falling edge, then go to RESP_LOW.
  - RESP_LOW: wait for a rising edge, then go to RESP_HIGH.
  - RESP_HIGH: wait for a falling edge, then go to DATA_LOW.
  - DATA_LOW: wait for a rising edge, then go to DATA_HIGH.
  - DATA_HIGH: on a falling edge, shift in a bit MSB-first. After bit 40, go to CHECK; otherwise go to DATA_LOW.
  - CHECK: one clk, then go to HOLDOFF.
  - HOLDOFF: wait until PERIOD_US has elapsed since the START_LOW entry, then go to IDLE.
- Each of RELEASE, RESP_LOW, RESP_HIGH, DATA_LOW and DATA_HIGH has its own µs counter, cleared on state entry. If the counter reaches TIMEOUT_US, the block pulses `timeout_err`, releases the bus and goes to HOLDOFF. The partial frame is discarded.
- The frame is bytes B0..B4. The checksum passes when (B0+B1+B2+B3) mod 256 == B4.
- On checksum pass:
  - DHT22: hum = {B0,B1}. temp = B2[7] ? −{1'b0,B2[6:0],B3} : {1'b0,B2[6:0],B3}.
  - DHT11: hum = B0·10 + B1[3:0]. temp = B2·10 + B3[3:0], or the negation of that if B3[7]=1.
  - After updating hum/temp, pulse `data_valid`.
- On checksum fail: pulse `crc_err`. hum and temp keep their previous values.
- A `start` pulse outside IDLE is ignored and not queued. In AUTO_MODE=1, `start` is ignored entirely.

## Timing
- Reset values: bus released (high-Z), busy=0, hum=0, temp=0, data_valid=0, crc_err=0, timeout_err=0. State is POWER_WAIT. All counters are 0.
- Reset mid-read releases the bus asynchronously on assertion and restarts at POWER_WAIT.
- Edge-detect latency is 2–3 clk from a pin transition. Bit duration is measured in whole µs, with ±1 µs quantisation.
- A high duration of exactly BIT_THRESH_US decodes as 0.
- `data_valid` and `crc_err` assert in the CHECK cycle, which is exactly 1 clk after the 40th falling edge is detected. hum/temp are stable from that same cycle.
- Status pulses are mutually exclusive. At most one of them fires per read.
- `busy` rises 1 clk after `start` is accepted, or after IDLE exit in AUTO_MODE.
- `busy` falls on the cycle IDLE is re-entered.

## Configuration
- Macro `DHT_ERRCNT_EN`.
- Defined: adds output `err_cnt [15:0]`. It increments on every `crc_err` or `timeout_err` pulse, saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- DHT22, sensor model sends 0x02 0x8C 0x01 0x5F 0xEE → data_valid pulse, hum=652, temp=351.
- DHT22, frame 0x02 0x8C 0x80 0x65 0x73 → temp=16'hFF9B (−10.1 °C), hum=652.
- DHT11, frame 0x2D 0x00 0x17 0x00 0x44; START_LOW measured as 18_000 µs → hum=450, temp=230.
- Frame with B4 corrupted to 0xEF → crc_err pulse, hum/temp unchanged, no data_valid.
- Sensor silent after release → timeout_err exactly TIMEOUT_US after release. The next start pulse occurs no earlier than PERIOD_US after the previous one.
- AUTO_MODE=0, `start` pulsed during DATA_HIGH and res asserted mid-frame → start ignored; bus high-Z immediately on reset; all outputs 0; err_cnt=0 with DHT_ERRCNT_EN.
